// File: rtl/p_to_s_if.sv
// rtl/p_to_s_if.sv - word-in / bit-out handshake bundle for p_to_s
interface p_to_s_if #(
  parameter int WIDTH = 6
);
  logic             valid_a;
  logic [WIDTH-1:0] data_a;
  logic             ready_a;
  logic             valid_b;
  logic             data_b;
  logic             last_b;
  logic             ready_b;

  modport master (
    output valid_a, data_a, ready_b,
    input  ready_a, valid_b, data_b, last_b
  );

  modport slave (
    input  valid_a, data_a, ready_b,
    output ready_a, valid_b, data_b, last_b
  );
endinterface

// File: rtl/p_to_s.sv
// rtl/p_to_s.sv - parallel-to-serial converter, LSB first, with one-word holding buffer
module p_to_s #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 3
) (
  input  logic     clk,
  input  logic     rst,
  p_to_s_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] hd_q, hd_d;
  logic             sh_v_q, sh_v_d;
  logic             hd_v_q, hd_v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_a_q, ready_a_d;

  logic xfer;
  logic done;
  logic acc;

  assign xfer = sh_v_q & bus.ready_b;
  assign done = xfer & (cnt_q == CNT_LAST);
  assign acc  = bus.valid_a & ready_a_q;

  always_comb begin
    sh_d   = sh_q;
    sh_v_d = sh_v_q;
    cnt_d  = cnt_q;
    hd_d   = hd_q;
    hd_v_d = hd_v_q;

    // Reload priority on word completion: held word first, then a fresh word.
    if (done) begin
      cnt_d = '0;
      if (hd_v_q) begin
        sh_d   = hd_q;
        hd_v_d = 1'b0;
      end else if (acc) begin
        sh_d = bus.data_a;
      end else begin
        sh_d   = '0;
        sh_v_d = 1'b0;
      end
    end else if (xfer) begin
      sh_d  = sh_q >> 1;
      cnt_d = cnt_q + CNT_W'(1);
    end

    // ready_a is low whenever hd is occupied, so done && acc implies hd was empty.
    if (acc) begin
      if (!sh_v_q) begin
        sh_d   = bus.data_a;
        sh_v_d = 1'b1;
        cnt_d  = '0;
      end else if (!done) begin
        hd_d   = bus.data_a;
        hd_v_d = 1'b1;
      end
    end

    ready_a_d = ~hd_v_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q      <= '0;
      sh_v_q    <= 1'b0;
      hd_q      <= '0;
      hd_v_q    <= 1'b0;
      cnt_q     <= '0;
      ready_a_q <= 1'b0;
    end else begin
      sh_q      <= sh_d;
      sh_v_q    <= sh_v_d;
      hd_q      <= hd_d;
      hd_v_q    <= hd_v_d;
      cnt_q     <= cnt_d;
      ready_a_q <= ready_a_d;
    end
  end

  assign bus.ready_a = ready_a_q;
  assign bus.valid_b = sh_v_q;
  assign bus.data_b  = sh_q[0];
  assign bus.last_b  = sh_v_q & (cnt_q == CNT_LAST);
endmodule

// File: tb/tb_p_to_s.sv
// tb/tb_p_to_s.sv - directed-vector bench for p_to_s at WIDTH=6 and WIDTH=8
module tb_p_to_s;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  p_to_s_if #(.WIDTH(6)) if6 ();
  p_to_s_if #(.WIDTH(8)) if8 ();

  p_to_s #(.WIDTH(6), .CNT_W(3)) u_dut6 (.clk(clk), .rst(rst), .bus(if6));
  p_to_s #(.WIDTH(8), .CNT_W(3)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle log of the 6-bit serial side.
  logic rec = 1'b0;
  logic lg_v[$];
  logic lg_d[$];
  logic lg_l[$];
  logic lg_r[$];

  always @(posedge clk) begin
    if (rec) begin
      lg_v.push_back(if6.valid_b);
      lg_d.push_back(if6.data_b);
      lg_l.push_back(if6.last_b);
      lg_r.push_back(if6.ready_b);
    end
  end

  // Receiver model: reassembles words and compares them with accepted words in order.
  logic [5:0] tx_q[$];
  logic [5:0] rx_sh = '0;
  int         rx_cnt = 0;
  int         rx_words = 0;

  always @(posedge clk) begin
    if (rst) begin
      tx_q.delete();
      rx_cnt = 0;
    end else begin
      if (if6.valid_a && if6.ready_a) tx_q.push_back(if6.data_a);
      if (if6.valid_b && if6.ready_b) begin
        rx_sh = {if6.data_b, rx_sh[5:1]};
        check("loopback_last", 32'(if6.last_b), 32'(rx_cnt == 5));
        if (rx_cnt == 5) begin
          rx_words++;
          if (tx_q.size() == 0) check("loopback_extra", 32'(tx_q.size()), 1);
          else check("loopback_word", 32'(rx_sh), 32'(tx_q.pop_front()));
          rx_cnt = 0;
        end else begin
          rx_cnt++;
        end
      end
    end
  end

  task automatic start_log();
    lg_v.delete();
    lg_d.delete();
    lg_l.delete();
    lg_r.delete();
    rec = 1'b1;
  endtask

  task automatic grab(input int n, output logic [31:0] bits, output logic [31:0] lasts,
                      output int span, output logic after_v);
    int cnt = 0;
    int first = -1;
    int last_i = -1;
    bits = '0;
    lasts = '0;
    span = 0;
    after_v = 1'b0;
    for (int i = 0; i < lg_v.size() && cnt < n; i++) begin
      if (lg_v[i] && lg_r[i]) begin
        if (first < 0) first = i;
        bits[cnt]  = lg_d[i];
        lasts[cnt] = lg_l[i];
        cnt++;
        last_i = i;
      end
    end
    if (first >= 0) span = last_i - first + 1;
    if (last_i >= 0 && last_i + 1 < lg_v.size()) after_v = lg_v[last_i + 1];
    check("grab_count", 32'(cnt), 32'(n));
  endtask

  task automatic push(input logic [5:0] w);
    int k = 0;
    if6.valid_a = 1'b1;
    if6.data_a  = w;
    while (!if6.ready_a && k < 200) begin
      tick();
      k++;
    end
    check("push_ready", 32'(if6.ready_a), 1);
    tick();
    if6.valid_a = 1'b0;
    if6.data_a  = '0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (if6.valid_b && k < 200) begin
      tick();
      k++;
    end
    check(tag, 32'(if6.valid_b), 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bits;
    logic [31:0] lasts;
    int          span;
    logic        after_v;
    logic [7:0]  v8;
    logic [7:0]  d8;
    logic [7:0]  l8;

    if6.valid_a = 1'b0;
    if6.data_a  = '0;
    if6.ready_b = 1'b1;
    if8.valid_a = 1'b0;
    if8.data_a  = '0;
    if8.ready_b = 1'b1;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_ready_a", 32'(if6.ready_a), 0);
    check("rst_valid_b", 32'(if6.valid_b), 0);
    check("rst_data_b",  32'(if6.data_b), 0);
    check("rst_last_b",  32'(if6.last_b), 0);
    check("rst_ready_a8", 32'(if8.ready_a), 0);
    rst = 1'b0;
    tick();
    check("rise_ready_a", 32'(if6.ready_a), 1);
    check("idle_valid_b", 32'(if6.valid_b), 0);

    // 1: single word
    start_log();
    push(6'b101101);
    check("t1_latency_valid", 32'(if6.valid_b), 1);
    check("t1_latency_bit0",  32'(if6.data_b), 1);
    wait_idle("t1_idle");
    rec = 1'b0;
    grab(6, bits, lasts, span, after_v);
    check("t1_bits",  bits,  32'h2D);
    check("t1_lasts", lasts, 32'h20);
    check("t1_span",  32'(span), 6);
    check("t1_after_valid", 32'(after_v), 0);

    // 2: back-to-back words
    start_log();
    push(6'h2A);
    push(6'h15);
    push(6'h3F);
    wait_idle("t2_idle");
    rec = 1'b0;
    grab(18, bits, lasts, span, after_v);
    check("t2_bits",  bits,  32'h3F56A);
    check("t2_lasts", lasts, 32'h20820);
    check("t2_span",  32'(span), 18);
    check("t2_after_valid", 32'(after_v), 0);

    // 3: backpressure after bit 1
    start_log();
    push(6'b000111);
    tick();
    tick();
    if6.ready_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t3_stall_valid", 32'(if6.valid_b), 1);
      check("t3_stall_data",  32'(if6.data_b), 1);
      check("t3_stall_last",  32'(if6.last_b), 0);
      tick();
    end
    check("t3_stall_hold", 32'(if6.data_b), 1);
    if6.ready_b = 1'b1;
    wait_idle("t3_idle");
    rec = 1'b0;
    grab(6, bits, lasts, span, after_v);
    check("t3_bits",  bits,  32'h07);
    check("t3_lasts", lasts, 32'h20);
    check("t3_span",  32'(span), 9);

    // 4: hold buffer full
    if6.ready_b = 1'b0;
    if6.valid_a = 1'b1;
    if6.data_a  = 6'h11;
    check("t4_ready_w1", 32'(if6.ready_a), 1);
    tick();
    check("t4_w1_valid", 32'(if6.valid_b), 1);
    check("t4_w1_bit0",  32'(if6.data_b), 1);
    check("t4_ready_w2", 32'(if6.ready_a), 1);
    if6.data_a = 6'h22;
    tick();
    check("t4_full_ready", 32'(if6.ready_a), 0);
    if6.data_a = 6'h33;
    tick();
    tick();
    tick();
    check("t4_full_stall", 32'(if6.ready_a), 0);
    if6.ready_b = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("t4_before_drain", 32'(if6.ready_a), 0);
    check("t4_last_bit", 32'(if6.last_b), 1);
    tick();
    check("t4_after_drain", 32'(if6.ready_a), 1);
    check("t4_w2_bit0", 32'(if6.data_b), 0);
    tick();
    if6.valid_a = 1'b0;
    check("t4_w3_to_hold", 32'(if6.ready_a), 0);
    wait_idle("t4_idle");

    // 5: reset mid-word
    push(6'h2A);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("t5_rst_valid", 32'(if6.valid_b), 0);
    check("t5_rst_last",  32'(if6.last_b), 0);
    check("t5_rst_data",  32'(if6.data_b), 0);
    check("t5_rst_ready", 32'(if6.ready_a), 0);
    rst = 1'b0;
    tick();
    check("t5_ready_back", 32'(if6.ready_a), 1);
    check("t5_no_residual", 32'(if6.valid_b), 0);
    start_log();
    push(6'h01);
    wait_idle("t5_idle");
    rec = 1'b0;
    grab(6, bits, lasts, span, after_v);
    check("t5_bits",  bits,  32'h01);
    check("t5_lasts", lasts, 32'h20);
    check("t5_span",  32'(span), 6);

    // 6: WIDTH=8 instance
    check("t6_ready", 32'(if8.ready_a), 1);
    if8.valid_a = 1'b1;
    if8.data_a  = 8'hA5;
    tick();
    if8.valid_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v8[i] = if8.valid_b;
      d8[i] = if8.data_b;
      l8[i] = if8.last_b;
      tick();
    end
    check("t6_valid", 32'(v8), 32'hFF);
    check("t6_bits",  32'(d8), 32'hA5);
    check("t6_lasts", 32'(l8), 32'h80);
    check("t6_idle",  32'(if8.valid_b), 0);

    check("loopback_count", 32'(rx_words), 9);
    check("loopback_pending", 32'(tx_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
